// File: rtl/crtc_char_shifter.sv
// Character-mode serializer behind the 6845: fetches code and glyph per slot and shifts 8 pixels.
// Optional attribute colour path is compiled in with `define VID_ATTR_EN.
module crtc_char_shifter #(
  parameter logic [3:0]  FG_COLOR     = 4'hF,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic        CLOCK,
  input  logic        nRESET,
  input  logic        PIX_CE,
  input  logic        CHAR_CE,
  input  logic [13:0] MA,
  input  logic [4:0]  RA,
  input  logic        DE,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic        CURSOR,
  output logic [13:0] VRAM_ADDR,
  input  logic [7:0]  VRAM_DATA,
  input  logic [3:0]  ATTR_DATA,
  output logic [10:0] CROM_ADDR,
  input  logic [7:0]  CROM_DATA,
  output logic        PIX_ON,
  output logic [3:0]  COLOR,
  output logic        DE_O,
  output logic        HS_O,
  output logic        VS_O
);

  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [2:0]        phase_q;
  logic              synced_q;
  logic [2:0]        ra_q;
  logic              de_q, hs_q, vs_q, cur_q;
  logic [7:0]        glyph_q;
  logic              glyph_ok_q;
  logic [7:0]        sreg_q;
  logic              cur_o_q;
  logic              vsync_prev_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_on_q;

  logic [1:0] unused_ra;
  assign unused_ra = RA[4:3];

  // Fetch stage, then hand-off to the output stage on each character boundary.
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      phase_q    <= 3'd0;
      synced_q   <= 1'b0;
      VRAM_ADDR  <= '0;
      CROM_ADDR  <= '0;
      ra_q       <= 3'd0;
      de_q       <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      cur_q      <= 1'b0;
      glyph_q    <= 8'h00;
      glyph_ok_q <= 1'b0;
      sreg_q     <= 8'h00;
      cur_o_q    <= 1'b0;
      DE_O       <= 1'b0;
      HS_O       <= 1'b0;
      VS_O       <= 1'b0;
    end else if (PIX_CE) begin
      if (CHAR_CE) begin
        phase_q <= 3'd0;
      end else if (phase_q != 3'd7) begin
        phase_q <= phase_q + 3'd1;
      end

      if (phase_q == 3'd0) begin
        VRAM_ADDR <= MA;
        ra_q      <= RA[2:0];
        de_q      <= DE;
        hs_q      <= HSYNC;
        vs_q      <= VSYNC;
        cur_q     <= CURSOR;
      end
      if (phase_q == 3'd2) begin
        CROM_ADDR <= {VRAM_DATA, ra_q};
      end
      // Until the first boundary after reset the phase is not slot-aligned, so keep that slot blank.
      if (phase_q == 3'd4 && synced_q) begin
        glyph_q    <= CROM_DATA;
        glyph_ok_q <= 1'b1;
      end

      if (CHAR_CE) begin
        synced_q   <= 1'b1;
        sreg_q     <= (glyph_ok_q && de_q) ? glyph_q : 8'h00;
        // An incomplete fetch blanks the whole slot, cursor included.
        cur_o_q    <= cur_q & glyph_ok_q;
        DE_O       <= de_q;
        HS_O       <= hs_q;
        VS_O       <= vs_q;
        glyph_ok_q <= 1'b0;
      end else begin
        sreg_q <= {sreg_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      vsync_prev_q <= 1'b0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
    end else if (PIX_CE) begin
      vsync_prev_q <= VSYNC;
      if (VSYNC && !vsync_prev_q) begin
        if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
          blink_cnt_q <= '0;
          blink_on_q  <= ~blink_on_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  assign PIX_ON = sreg_q[7] ^ (cur_o_q & blink_on_q & DE_O);

`ifdef VID_ATTR_EN
  logic [3:0] attr_q, attr_o_q;

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      attr_q   <= 4'h0;
      attr_o_q <= 4'h0;
    end else if (PIX_CE) begin
      if (phase_q == 3'd2) begin
        attr_q <= ATTR_DATA;
      end
      if (CHAR_CE) begin
        attr_o_q <= attr_q;
      end
    end
  end

  assign COLOR = PIX_ON ? attr_o_q : 4'h0;
`else
  logic [3:0] unused_attr;
  assign unused_attr = ATTR_DATA;

  assign COLOR = PIX_ON ? FG_COLOR : 4'h0;
`endif

endmodule

// File: tb/tb_crtc_char_shifter.sv
// Scoreboard bench for crtc_char_shifter: directed CRTC slots, per-pixel expectations checked by a monitor.
module tb_crtc_char_shifter;

`ifdef VID_ATTR_EN
  localparam bit AttrOn = 1'b1;
`else
  localparam bit AttrOn = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        nRESET = 1'b0;
  logic        PIX_CE = 1'b0;
  logic        CHAR_CE = 1'b0;
  logic [13:0] MA = '0;
  logic [4:0]  RA = '0;
  logic        DE = 1'b0, HSYNC = 1'b0, VSYNC = 1'b0, CURSOR = 1'b0;
  logic [13:0] VRAM_ADDR;
  logic [7:0]  VRAM_DATA;
  logic [3:0]  ATTR_DATA;
  logic [10:0] CROM_ADDR;
  logic [7:0]  CROM_DATA;
  logic        PIX_ON;
  logic [3:0]  COLOR;
  logic        DE_O, HS_O, VS_O;

  logic [7:0] vram [0:16383];
  logic [3:0] attr [0:16383];
  logic [7:0] crom [0:2047];

  assign VRAM_DATA = vram[VRAM_ADDR];
  assign ATTR_DATA = attr[VRAM_ADDR];
  assign CROM_DATA = crom[CROM_ADDR];

  crtc_char_shifter #(.FG_COLOR(4'hF), .BLINK_FRAMES(16)) dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .PIX_CE(PIX_CE), .CHAR_CE(CHAR_CE),
    .MA(MA), .RA(RA), .DE(DE), .HSYNC(HSYNC), .VSYNC(VSYNC), .CURSOR(CURSOR),
    .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA(VRAM_DATA), .ATTR_DATA(ATTR_DATA),
    .CROM_ADDR(CROM_ADDR), .CROM_DATA(CROM_DATA),
    .PIX_ON(PIX_ON), .COLOR(COLOR), .DE_O(DE_O), .HS_O(HS_O), .VS_O(VS_O)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] exp;   // {PIX_ON, COLOR, DE_O, HS_O, VS_O}
    string      name;
  } item_t;

  item_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  // Monitor: compares every expectation scheduled for the current cycle, away from the active edge.
  always @(negedge CLOCK) begin
    item_t it;
    logic [7:0] act;
    act = {PIX_ON, COLOR, DE_O, HS_O, VS_O};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      n_vec++;
      if (it.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                 it.name, it.cyc, cyc);
      end else if (act !== it.exp) begin
        n_bad++;
        $display("FAIL %s: got {pix,col,de,hs,vs}=%b required %b", it.name, act, it.exp);
      end
    end
  end

  function automatic logic [3:0] fgc(input logic [3:0] a);
    return AttrOn ? a : 4'hF;
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // One CRTC slot of len pixel clocks; ep/ec/ede/ehs/evs describe what the outputs show meanwhile.
  task automatic slot(input int id, input int len, input logic [13:0] ma, input logic de,
                      input logic hs, input logic vs, input logic cur, input logic [7:0] ep,
                      input logic [3:0] ec, input logic ede, input logic ehs, input logic evs);
    item_t it;
    MA = ma; DE = de; HSYNC = hs; VSYNC = vs; CURSOR = cur;
    PIX_CE = 1'b1; CHAR_CE = 1'b0;
    for (int k = 0; k < len; k++) begin
      it.cyc  = cyc + k;
      it.exp  = {ep[7-k], (ep[7-k] ? ec : 4'h0), ede, ehs, evs};
      it.name = $sformatf("slot%0d_px%0d", id, k);
      sb.push_back(it);
    end
    for (int k = 0; k < len; k++) begin
      CHAR_CE = (k == len - 1);
      tick();
    end
    CHAR_CE = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      vram[i] = 8'h00;
      attr[i] = 4'h0;
    end
    for (int i = 0; i < 2048; i++) crom[i] = 8'h00;
    vram[1] = 8'h41; attr[1] = 4'h3; crom[{8'h41, 3'd0}] = 8'b1010_0101;
    vram[2] = 8'h42; attr[2] = 4'h6; crom[{8'h42, 3'd0}] = 8'hF0;
    vram[3] = 8'h00; attr[3] = 4'h9;

    nRESET = 1'b0; PIX_CE = 1'b1;
    repeat (3) tick();
    nRESET = 1'b1;

    // Post-reset: first period is reset state, first transferred slot is blank.
    slot(1, 8, 14'd1, 1, 0, 0, 0, 8'h00, 4'h0, 0, 0, 0);
    slot(2, 8, 14'd1, 1, 1, 0, 0, 8'h00, 4'h0, 1, 0, 0);
    slot(3, 8, 14'd1, 0, 0, 0, 0, 8'hA5, fgc(4'h3), 1, 1, 0);
    // DE fell in slot 3: slot 4 period is blank with DE_O low.
    slot(4, 8, 14'd2, 1, 0, 0, 0, 8'h00, 4'h0, 0, 0, 0);
    slot(5, 8, 14'd3, 1, 0, 0, 1, 8'hF0, fgc(4'h6), 1, 0, 0);
    // Cursor over an empty glyph lights all 8 pixels.
    slot(6, 8, 14'd1, 1, 0, 0, 0, 8'hFF, fgc(4'h9), 1, 0, 0);
    // Early boundary at phase 3: slot 7 data is blanked but its HSYNC still comes through.
    slot(7, 4, 14'd1, 1, 1, 0, 0, 8'hA5, fgc(4'h3), 1, 0, 0);
    slot(8, 8, 14'd1, 1, 0, 0, 0, 8'h00, 4'h0, 1, 1, 0);
    slot(9, 8, 14'd0, 1, 0, 0, 0, 8'hA5, fgc(4'h3), 1, 0, 0);
    slot(10, 8, 14'd3, 1, 0, 0, 1, 8'h00, 4'h0, 1, 0, 0);
    slot(11, 8, 14'd0, 0, 0, 1, 0, 8'hFF, fgc(4'h9), 1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      slot(100 + 2 * i, 8, 14'd0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 1);
      slot(101 + 2 * i, 8, 14'd0, 0, 0, 1, 0, 8'h00, 4'h0, 0, 0, 0);
    end
    // Sixteen VSYNC edges later the cursor is in its off half-period.
    slot(12, 8, 14'd3, 1, 0, 0, 1, 8'h00, 4'h0, 0, 0, 1);
    slot(13, 8, 14'd1, 1, 0, 0, 0, 8'h00, 4'h0, 1, 0, 0);
    slot(14, 8, 14'd1, 1, 0, 0, 0, 8'hA5, fgc(4'h3), 1, 0, 0);

    // One-clock reset in the middle of a slot.
    MA = 14'd1; DE = 1'b1; HSYNC = 1'b0; VSYNC = 1'b0; CURSOR = 1'b0;
    repeat (3) tick();
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    slot(20, 8, 14'd1, 1, 0, 0, 0, 8'h00, 4'h0, 0, 0, 0);
    slot(21, 8, 14'd1, 1, 0, 0, 0, 8'h00, 4'h0, 1, 0, 0);
    slot(22, 8, 14'd1, 1, 0, 0, 0, 8'hA5, fgc(4'h3), 1, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: never checked (cycle %0d, expected %b)", it.name, it.cyc, it.exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
